// File: rtl/iter_shifter_if.sv
// Handshake bundle between a shift requester and iter_shifter.
// The requester is the master; the shifter is the slave.
interface iter_shifter_if #(
  parameter int WIDTH = 16
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] in;
  logic [AMT_W-1:0] amt;
  logic [2:0]       oper;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             err;

  modport master (
    output start, in, amt, oper,
    input  busy, done, out, err
  );

  modport slave (
    input  start, in, amt, oper,
    output busy, done, out, err
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bits per clock
// until the requested amount is consumed, then pulses done.
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 2
) (
  input logic          clk,
  input logic          rst,
  iter_shifter_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);

  typedef logic [AMT_W:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  state_t           state, state_n;
  logic [WIDTH-1:0] out_q, nxt;
  cnt_t             rem, s, rem_n;
  logic [2:0]       op_q;
  logic             err_q;
  logic             legal;

  assign legal = (bus.oper <= OP_SRA);

  // rem is one bit wider so STEP == WIDTH still fits
  assign s     = (rem < cnt_t'(STEP)) ? rem : cnt_t'(STEP);
  assign rem_n = rem - s;

  // Only STEP candidate shifts exist; s selects one of them
  always_comb begin
    nxt = out_q;
    for (int k = 1; k <= STEP; k++) begin
      if (s == cnt_t'(k)) begin
        case (op_q)
          OP_ROL: nxt = (out_q << k) | (out_q >> (WIDTH - k));
          OP_SLL: nxt = out_q << k;
          OP_ROR: nxt = (out_q >> k) | (out_q << (WIDTH - k));
          OP_SRL: nxt = out_q >> k;
          OP_SRA: nxt = $unsigned($signed(out_q) >>> k);
          default: nxt = out_q;
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.amt != '0 && legal) state_n = SHIFT;
          else                        state_n = DONE;
        end
      end
      SHIFT: begin
        if (rem_n == '0) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
      rem   <= '0;
      op_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        out_q <= bus.in;
        rem   <= {1'b0, bus.amt};
        op_q  <= bus.oper;
        err_q <= ~legal;
      end else if (state == SHIFT) begin
        out_q <= nxt;
        rem   <= rem_n;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.err  = (state == DONE) && err_q;
  assign bus.out  = out_q;
endmodule

// File: tb/tb_iter_shifter.sv
// Directed checks of iter_shifter at 16/2, 8/8 and 8/1.
// Inputs change and outputs are sampled on the falling edge.
module tb_iter_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  iter_shifter_if #(.WIDTH(16)) b16 ();
  iter_shifter_if #(.WIDTH(8))  b88 ();
  iter_shifter_if #(.WIDTH(8))  b81 ();

  iter_shifter #(.WIDTH(16), .STEP(2)) u16 (
    .clk (clk), .rst (rst), .bus (b16.slave)
  );
  iter_shifter #(.WIDTH(8), .STEP(8)) u88 (
    .clk (clk), .rst (rst), .bus (b88.slave)
  );
  iter_shifter #(.WIDTH(8), .STEP(1)) u81 (
    .clk (clk), .rst (rst), .bus (b81.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // poke: cycle in which a stray start with in=FFFF is driven
  task automatic run16(input string tag,
                       input logic [15:0] a,
                       input logic [3:0] amt,
                       input logic [2:0] op,
                       input logic [15:0] eo,
                       input logic ee,
                       input int ecyc,
                       input int poke);
    int c;
    bit seen;
    @(negedge clk);
    b16.start = 1'b1;
    b16.in    = a;
    b16.amt   = amt;
    b16.oper  = op;
    @(negedge clk);
    c    = 1;
    seen = 1'b0;
    b16.in   = ~a;
    b16.amt  = ~amt;
    b16.oper = 3'b001;
    while (!seen && c <= 40) begin
      chk({tag, "_busy"}, b16.busy, 1);
      if (b16.done) begin
        seen = 1'b1;
        chk({tag, "_cyc"}, c, ecyc);
        chk({tag, "_out"}, b16.out, eo);
        chk({tag, "_err"}, b16.err, ee);
      end
      if (c == poke) begin
        b16.start = 1'b1;
        b16.in    = 16'hFFFF;
      end else begin
        b16.start = 1'b0;
      end
      if (!seen) begin
        @(negedge clk);
        c++;
      end
    end
    b16.start = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, "_idle"}, {b16.busy, b16.done}, 0);
  endtask

  task automatic run8(input int sel,
                      input string tag,
                      input logic [7:0] a,
                      input logic [2:0] amt,
                      input logic [2:0] op,
                      input logic [7:0] eo,
                      input int ecyc);
    int c;
    bit seen;
    @(negedge clk);
    if (sel == 0) begin
      b88.start = 1'b1; b88.in = a; b88.amt = amt; b88.oper = op;
    end else begin
      b81.start = 1'b1; b81.in = a; b81.amt = amt; b81.oper = op;
    end
    @(negedge clk);
    b88.start = 1'b0;
    b81.start = 1'b0;
    c    = 1;
    seen = 1'b0;
    while (!seen && c <= 40) begin
      if (sel == 0 ? b88.done : b81.done) begin
        seen = 1'b1;
        chk({tag, "_cyc"}, c, ecyc);
        chk({tag, "_out"}, sel == 0 ? b88.out : b81.out, eo);
        chk({tag, "_err"}, sel == 0 ? b88.err : b81.err, 0);
      end else begin
        @(negedge clk);
        c++;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int pulses;
    b16.start = 1'b0; b16.in = '0; b16.amt = '0; b16.oper = '0;
    b88.start = 1'b0; b88.in = '0; b88.amt = '0; b88.oper = '0;
    b81.start = 1'b0; b81.in = '0; b81.amt = '0; b81.oper = '0;
    b16.in = 16'h5555;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", b16.busy, 0);
    chk("rst_done", b16.done, 0);
    chk("rst_err",  b16.err,  0);
    chk("rst_out",  b16.out,  0);

    run16("srl",   16'hF00F, 4'd4,  3'b011, 16'h0F00, 0, 3, 0);
    run16("rol3",  16'h8001, 4'd3,  3'b000, 16'h000C, 0, 3, 0);
    run16("ror1",  16'h0001, 4'd1,  3'b010, 16'h8000, 0, 2, 0);
    run16("sra15", 16'h8010, 4'd15, 3'b100, 16'hFFFF, 0, 9, 0);
    run16("sra4",  16'h7FF0, 4'd4,  3'b100, 16'h07FF, 0, 3, 0);
    run16("sll5",  16'h00F1, 4'd5,  3'b001, 16'h1E20, 0, 4, 0);
    run16("zero",  16'h1234, 4'd0,  3'b001, 16'h1234, 0, 1, 0);
    run16("ill",   16'hABCD, 4'd5,  3'b110, 16'hABCD, 1, 1, 0);
    run16("busy",  16'hF00F, 4'd4,  3'b011, 16'h0F00, 0, 3, 2);
    chk("hold_out", b16.out, 16'h0F00);

    // reset in cycle 2 of a long SRA
    @(negedge clk);
    b16.start = 1'b1;
    b16.in    = 16'h8010;
    b16.amt   = 4'd15;
    b16.oper  = 3'b100;
    @(negedge clk);
    b16.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", b16.busy, 0);
    chk("mid_rst_out",  b16.out,  0);
    chk("mid_rst_done", b16.done, 0);
    rst    = 1'b0;
    pulses = 0;
    repeat (14) begin
      @(negedge clk);
      if (b16.done) pulses++;
    end
    chk("mid_rst_nodone", pulses, 0);

    run8(0, "w8s8_ror", 8'h96, 3'd3, 3'b010, 8'hD2, 2);
    run8(1, "w8s1_sll", 8'h01, 3'd7, 3'b001, 8'h80, 8);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the fixed 2-bit shift stage.
- Shifts or rotates a WIDTH-bit operand by a run-time amount (0..WIDTH-1), moving up to STEP bits per clock.
- Adds arithmetic shift right, a start/busy/done handshake and illegal-opcode flagging.
- Sits beside the ALU as the shared shift resource for variable-amount shift/rotate instructions.

Parameters:
- WIDTH, 16, operand/result width in bits; power of two, >= 4.
- STEP, 2, maximum bits shifted per clock; power of two, 1 <= STEP <= WIDTH.
- AMT_W, clog2(WIDTH), derived localparam: width of the shift-amount port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- in  input  WIDTH  operand. Captured on the accepted start.
- amt  input  AMT_W  shift amount. Captured on the accepted start.
- oper  input  3  operation: 000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA; 101-111 illegal.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; out is valid in this cycle.
- out  output  WIDTH  working/result register.
- err  output  1  high only with done, when the accepted oper was illegal.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state: state=IDLE, out=0, busy=0, done=0, err=0, remaining-count=0.
- rst asserted in any state, including mid-SHIFT: the operation is abandoned with no done pulse, and all reset values appear in the next cycle.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> load out<=in, latch oper and rem<=amt.
  - Next state is SHIFT if amt!=0 and oper is legal; otherwise DONE.
  - start=0 -> stay in IDLE; out holds its value.
- SHIFT, each cycle:
  - s = min(STEP, rem).
  - Apply oper by s bits to out; rem <= rem - s.
  - If rem - s == 0, go to DONE; else stay in SHIFT.
- DONE: done=1 and err as latched; go to IDLE next cycle. out holds its value until the next accepted start.
- Latency: start high in cycle 0 -> done high in cycle N+1, where N = ceil(amt/STEP). For amt=0 or an illegal oper, N=0.
- Operations per step:
  - ROL/ROR: rotation; bits leaving one end re-enter at the other.
  - SLL: zero fill on the LSB side.
  - SRL: zero fill on the MSB side.
  - SRA: fill with the current MSB (the original sign bit, invariant across steps).
- Illegal oper: out = in unchanged, err=1 coincident with done. No shifting occurs.
- Partial final step: when amt is not a multiple of STEP, the last step shifts rem < STEP bits. The result must equal a single shift by amt.
- start while busy (SHIFT or DONE): ignored. in, amt and oper changes have no effect on the active operation. No queuing.
- out during SHIFT shows intermediate values; consumers must qualify it with done.
- Shift logic is a STEP-wide mux per oper plus a remaining-count register; no full barrel shifter.

Test Plan:
- WIDTH=16, STEP=2, SRL: in=0xF00F, amt=4, start in cycle 0 -> done only in cycle 3, out=0x0F00, err=0; busy high in cycles 1-3.
- WIDTH=16, STEP=2, ROL (partial step): in=0x8001, amt=3 -> done in cycle 3, out=0x000C. Second case, ROR: in=0x0001, amt=1 -> done in cycle 2, out=0x8000.
- WIDTH=16, STEP=2, SRA: in=0x8010, amt=15 -> done in cycle 9, out=0xFFFF. Same with in=0x7FF0, SRA amt=4 -> out=0x07FF.
- Zero amount: amt=0, SLL, in=0x1234 -> done in cycle 1, out=0x1234. Illegal oper: oper=3'b110, in=0xABCD, amt=5 -> done in cycle 1, err=1, out=0xABCD.
- Start while busy: second start with in=0xFFFF in cycle 2 of the first operation -> ignored, first result delivered unchanged. Reset: rst in cycle 2 of amt=15 SRA -> cycle 3: busy=0, out=0, done never pulses.
- Alternate parameters:
  - WIDTH=8, STEP=8, ROR: in=0x96, amt=3 -> done in cycle 2, out=0xD2.
  - WIDTH=8, STEP=1, SLL: in=0x01, amt=7 -> done in cycle 8, out=0x80.
